// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: two one-entry request buffers (ALU, load) feeding the register file's
// single registered write port, plus a pending-write mask for decode. RF_WB_RR_EN selects round-robin.
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 alu_valid,
    input  logic [AW-1:0]        alu_rd,
    input  logic [DW-1:0]        alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [AW-1:0]        mem_rd,
    input  logic [DW-1:0]        mem_data,
    output logic                 mem_ready,
    output logic                 WrEn,
    output logic [AW-1:0]        Rw,
    output logic [DW-1:0]        busW,
    output logic [(1<<AW)-1:0]   pend_mask,
    output logic                 busy
);

    localparam int NR = 1 << AW;

    logic          alu_full_q, alu_full_d;
    logic [AW-1:0] alu_rd_q,   alu_rd_d;
    logic [DW-1:0] alu_data_q, alu_data_d;
    logic          mem_full_q, mem_full_d;
    logic [AW-1:0] mem_rd_q,   mem_rd_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic          wr_en_q,    wr_en_d;
    logic [AW-1:0] rw_q,       rw_d;
    logic [DW-1:0] busw_q,     busw_d;

    logic grant_alu, grant_mem, mem_wins;
    logic alu_acc, mem_acc;

`ifdef RF_WB_RR_EN
    logic last_alu_q, last_alu_d;

    // MEM wins a contended grant whenever ALU was the last one served.
    assign mem_wins = last_alu_q;

    always_comb begin
        last_alu_d = last_alu_q;
        if (grant_mem) begin
            last_alu_d = 1'b0;
        end else if (grant_alu) begin
            last_alu_d = 1'b1;
        end
    end
`else
    assign mem_wins = 1'b1;
`endif

    // Grant looks only at buffer state, never at the valid inputs, so ready has no path from valid.
    assign grant_mem = mem_full_q && (!alu_full_q || mem_wins);
    assign grant_alu = alu_full_q && !grant_mem;

    assign alu_ready = !alu_full_q || grant_alu;
    assign mem_ready = !mem_full_q || grant_mem;
    assign alu_acc   = alu_valid && alu_ready;
    assign mem_acc   = mem_valid && mem_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        alu_full_d = alu_full_q;
        alu_rd_d   = alu_rd_q;
        alu_data_d = alu_data_q;
        mem_full_d = mem_full_q;
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;

        // An accept without a grant implies the buffer was empty, so clearing on grant alone covers x0 accepts.
        if (alu_acc && alu_rd != '0) begin
            alu_full_d = 1'b1;
            alu_rd_d   = alu_rd;
            alu_data_d = alu_data;
        end else if (grant_alu) begin
            alu_full_d = 1'b0;
        end

        if (mem_acc && mem_rd != '0) begin
            mem_full_d = 1'b1;
            mem_rd_d   = mem_rd;
            mem_data_d = mem_data;
        end else if (grant_mem) begin
            mem_full_d = 1'b0;
        end
    end

    always_comb begin
        wr_en_d = grant_alu || grant_mem;
        rw_d    = rw_q;
        busw_d  = busw_q;
        if (grant_mem) begin
            rw_d   = mem_rd_q;
            busw_d = mem_data_q;
        end else if (grant_alu) begin
            rw_d   = alu_rd_q;
            busw_d = alu_data_q;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            alu_full_q <= 1'b0;
            alu_rd_q   <= '0;
            alu_data_q <= '0;
            mem_full_q <= 1'b0;
            mem_rd_q   <= '0;
            mem_data_q <= '0;
            wr_en_q    <= 1'b0;
            rw_q       <= '0;
            busw_q     <= '0;
`ifdef RF_WB_RR_EN
            last_alu_q <= 1'b1;
`endif
        end else begin
            // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
            alu_full_q <= alu_full_d;
            alu_rd_q   <= alu_rd_d;
            alu_data_q <= alu_data_d;
            mem_full_q <= mem_full_d;
            mem_rd_q   <= mem_rd_d;
            mem_data_q <= mem_data_d;
            wr_en_q    <= wr_en_d;
            rw_q       <= rw_d;
            busw_q     <= busw_d;
`ifdef RF_WB_RR_EN
            last_alu_q <= last_alu_d;
`endif
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int r = 1; r < NR; r++) begin
            pend_mask[r] = (alu_full_q && alu_rd_q == AW'(r)) ||
                           (mem_full_q && mem_rd_q == AW'(r)) ||
                           (wr_en_q    && rw_q     == AW'(r));
        end
    end

    assign WrEn = wr_en_q;
    assign Rw   = rw_q;
    assign busW = busw_q;
    assign busy = alu_full_q || mem_full_q || wr_en_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_rf_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 1 << AW;
`ifdef RF_WB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          alu_valid, mem_valid;
    logic [AW-1:0] alu_rd, mem_rd;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic          WrEn;
    logic [AW-1:0] Rw;
    logic [DW-1:0] busW;
    logic [NR-1:0] pend_mask;
    logic          busy;

    rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .WrEn(WrEn), .Rw(Rw), .busW(busW), .pend_mask(pend_mask), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model: pending writes per producer + output stage ----------------
    typedef struct {
        bit            full;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } slot_t;

    slot_t             m_alu, m_mem;
    bit                m_wren;
    logic [AW-1:0]     m_rw;
    logic [DW-1:0]     m_busw;
    bit                m_last_alu;
    logic [AW+DW-1:0]  m_log[$];

    function automatic void model_reset();
        m_alu.full = 1'b0; m_alu.rd = '0; m_alu.data = '0;
        m_mem.full = 1'b0; m_mem.rd = '0; m_mem.data = '0;
        m_wren = 1'b0; m_rw = '0; m_busw = '0;
        m_last_alu = 1'b1;
    endfunction

    // Who is served this cycle: a lone pending write always; a contended pair by priority rule.
    function automatic bit mdl_serve_mem();
        if (m_mem.full && m_alu.full) return RR ? m_last_alu : 1'b1;
        return m_mem.full;
    endfunction

    function automatic bit mdl_serve_alu();
        return m_alu.full && !mdl_serve_mem();
    endfunction

    function automatic bit mdl_alu_ready();
        return !m_alu.full || mdl_serve_alu();
    endfunction

    function automatic bit mdl_mem_ready();
        return !m_mem.full || mdl_serve_mem();
    endfunction

    function automatic logic [NR-1:0] mdl_pend();
        logic [NR-1:0] m = '0;
        if (m_alu.full) m[m_alu.rd] = 1'b1;
        if (m_mem.full) m[m_mem.rd] = 1'b1;
        if (m_wren)     m[m_rw]     = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_step();
        bit sm, sa, ar, mr;
        if (!RSTn) begin
            model_reset();
            return;
        end
        sm = mdl_serve_mem();
        sa = mdl_serve_alu();
        ar = mdl_alu_ready();
        mr = mdl_mem_ready();
        if (sm) begin
            m_wren = 1'b1; m_rw = m_mem.rd; m_busw = m_mem.data; m_last_alu = 1'b0;
            m_log.push_back({m_rw, m_busw});
        end else if (sa) begin
            m_wren = 1'b1; m_rw = m_alu.rd; m_busw = m_alu.data; m_last_alu = 1'b1;
            m_log.push_back({m_rw, m_busw});
        end else begin
            m_wren = 1'b0;
        end
        if (alu_valid && ar) begin
            m_alu.full = (alu_rd != '0); m_alu.rd = alu_rd; m_alu.data = alu_data;
        end else if (sa) begin
            m_alu.full = 1'b0;
        end
        if (mem_valid && mr) begin
            m_mem.full = (mem_rd != '0); m_mem.rd = mem_rd; m_mem.data = mem_data;
        end else if (sm) begin
            m_mem.full = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTn = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        total++; if (WrEn !== 1'b0)     begin bad++; $display("FAIL rst_wren: got %0b exp 0", WrEn); end
        total++; if (Rw !== '0)         begin bad++; $display("FAIL rst_rw: got %0d exp 0", Rw); end
        total++; if (busW !== '0)       begin bad++; $display("FAIL rst_busw: got %0h exp 0", busW); end
        total++; if (pend_mask !== '0)  begin bad++; $display("FAIL rst_pend: got %0h exp 0", pend_mask); end
        total++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1)
            begin bad++; $display("FAIL rst_ready: got %0b%0b exp 11", alu_ready, mem_ready); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %0b exp 0", busy); end

        // Fill both buffers with a write in flight, then reset mid-cycle.
        @(negedge CLK);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
        tick();
        @(negedge CLK);
        alu_rd = 5'd7; mem_rd = 5'd9;
        tick();
        total++; if (WrEn !== 1'b1 || busy !== 1'b1)
            begin bad++; $display("FAIL rst_pre: got wren=%0b busy=%0b exp 1 1", WrEn, busy); end
        RSTn = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        total++; if (WrEn !== 1'b0)     begin bad++; $display("FAIL rst_mid_wren: got %0b exp 0", WrEn); end
        total++; if (Rw !== '0 || busW !== '0)
            begin bad++; $display("FAIL rst_mid_bus: got rw=%0d busw=%0h exp 0 0", Rw, busW); end
        total++; if (pend_mask !== '0)  begin bad++; $display("FAIL rst_mid_pend: got %0h exp 0", pend_mask); end
        total++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1)
            begin bad++; $display("FAIL rst_mid_ready: got %0b%0b exp 11", alu_ready, mem_ready); end
        tick();
        @(negedge CLK);
        RSTn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (WrEn !== 1'b0 || pend_mask !== '0)
                begin bad++; $display("FAIL rst_after_%0d: got wren=%0b pend=%0h exp 0 0", i, WrEn, pend_mask); end
        end
    endtask

    task automatic test_single_alu();
        @(negedge CLK);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %0b exp 1", alu_ready); end
        tick();
        total++; if (WrEn !== 1'b0 || pend_mask[5] !== 1'b1)
            begin bad++; $display("FAIL single_n: got wren=%0b pend5=%0b exp 0 1", WrEn, pend_mask[5]); end
        @(negedge CLK);
        alu_valid = 1'b0;
        tick();
        total++; if (WrEn !== 1'b1 || Rw !== 5'd5 || busW !== 32'hDEADBEEF)
            begin bad++; $display("FAIL single_wr: got %0b/%0d/%0h exp 1/5/deadbeef", WrEn, Rw, busW); end
        total++; if (pend_mask !== 32'h20) begin bad++; $display("FAIL single_pend: got %0h exp 20", pend_mask); end
        tick();
        total++; if (WrEn !== 1'b0 || pend_mask !== '0 || busy !== 1'b0)
            begin bad++; $display("FAIL single_done: got %0b/%0h/%0b exp 0/0/0", WrEn, pend_mask, busy); end
    endtask

    task automatic test_simultaneous();
        @(negedge CLK);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'd1;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'd2;
        #1;
        total++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1)
            begin bad++; $display("FAIL simul_ready0: got %0b%0b exp 11", alu_ready, mem_ready); end
        tick();
        @(negedge CLK);
        idle_inputs();
        #1;
        total++; if (alu_ready !== 1'b0 || mem_ready !== 1'b1)
            begin bad++; $display("FAIL simul_ready1: got %0b%0b exp 01", alu_ready, mem_ready); end
        total++; if (pend_mask !== 32'h18) begin bad++; $display("FAIL simul_pend: got %0h exp 18", pend_mask); end
        tick();
        total++; if (WrEn !== 1'b1 || Rw !== 5'd4 || busW !== 32'd2)
            begin bad++; $display("FAIL simul_first: got %0b/%0d/%0h exp 1/4/2", WrEn, Rw, busW); end
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL simul_ready2: got %0b exp 1", alu_ready); end
        tick();
        total++; if (WrEn !== 1'b1 || Rw !== 5'd3 || busW !== 32'd1)
            begin bad++; $display("FAIL simul_second: got %0b/%0d/%0h exp 1/3/1", WrEn, Rw, busW); end
        tick();
        total++; if (WrEn !== 1'b0) begin bad++; $display("FAIL simul_end: got %0b exp 0", WrEn); end
    endtask

    task automatic test_x0();
        @(negedge CLK);
        mem_valid = 1'b1; mem_rd = '0; mem_data = 32'h55;
        #1;
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL x0_ready: got %0b exp 1", mem_ready); end
        tick();
        total++; if (WrEn !== 1'b0 || pend_mask !== '0 || busy !== 1'b0)
            begin bad++; $display("FAIL x0_buf: got %0b/%0h/%0b exp 0/0/0", WrEn, pend_mask, busy); end
        @(negedge CLK);
        mem_valid = 1'b0;
        tick();
        total++; if (WrEn !== 1'b0) begin bad++; $display("FAIL x0_wr: got %0b exp 0", WrEn); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            alu_valid = (i < 8);
            alu_rd    = AW'(i + 1);
            alu_data  = 32'h100 + i;
            #1;
            if (i < 8) begin
                total++; if (alu_ready !== 1'b1)
                    begin bad++; $display("FAIL b2b_ready_%0d: got %0b exp 1", i, alu_ready); end
            end
            tick();
            if (i >= 1 && i <= 8) begin
                total++; if (WrEn !== 1'b1 || Rw !== AW'(i) || busW !== 32'h100 + i - 1)
                    begin bad++; $display("FAIL b2b_wr_%0d: got %0b/%0d/%0h exp 1/%0d/%0h", i, WrEn, Rw, busW, i, 32'h100 + i - 1); end
            end else if (i == 9) begin
                total++; if (WrEn !== 1'b0) begin bad++; $display("FAIL b2b_end: got %0b exp 0", WrEn); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            alu_valid = ($urandom_range(0, 9) < 6);
            mem_valid = ($urandom_range(0, 9) < 6);
            alu_rd    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, NR - 1));
            mem_rd    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, NR - 1));
            alu_data  = $urandom();
            mem_data  = $urandom();
            #1;
            total++; if (alu_ready !== mdl_alu_ready() || mem_ready !== mdl_mem_ready())
                begin bad++; $display("FAIL rnd_ready c=%0d: got %0b%0b exp %0b%0b", c, alu_ready, mem_ready, mdl_alu_ready(), mdl_mem_ready()); end
            total++; if (WrEn !== m_wren || Rw !== m_rw || busW !== m_busw)
                begin bad++; $display("FAIL rnd_wr c=%0d: got %0b/%0d/%0h exp %0b/%0d/%0h", c, WrEn, Rw, busW, m_wren, m_rw, m_busw); end
            total++; if (pend_mask !== mdl_pend() || busy !== (m_alu.full || m_mem.full || m_wren))
                begin bad++; $display("FAIL rnd_pend c=%0d: got %0h/%0b exp %0h", c, pend_mask, busy, mdl_pend()); end
            tick();
        end
        @(negedge CLK);
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_both_stream();
        int               a_next = 1;
        int               m_next = 17;
        bit               ar, mr;
        logic [AW+DW-1:0] obs[$];
        do_reset();
        m_log.delete();
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            alu_valid = (c < 10); alu_rd = AW'(a_next); alu_data = 32'hA000 + a_next;
            mem_valid = (c < 10); mem_rd = AW'(m_next); mem_data = 32'hB000 + m_next;
            #1;
            ar = mdl_alu_ready();
            mr = mdl_mem_ready();
            total++; if (alu_ready !== ar || mem_ready !== mr)
                begin bad++; $display("FAIL both_ready c=%0d: got %0b%0b exp %0b%0b", c, alu_ready, mem_ready, ar, mr); end
            if (WrEn === 1'b1) obs.push_back({Rw, busW});
            tick();
            if (alu_valid && ar) a_next++;
            if (mem_valid && mr) m_next++;
        end
        idle_inputs();
        total++; if (obs.size() != m_log.size() || obs.size() != (a_next - 1) + (m_next - 17))
            begin bad++; $display("FAIL both_count: got %0d exp %0d", obs.size(), m_log.size()); end
        for (int i = 0; i < obs.size() && i < m_log.size(); i++) begin
            total++; if (obs[i] !== m_log[i])
                begin bad++; $display("FAIL both_seq_%0d: got %0h exp %0h", i, obs[i], m_log[i]); end
        end
        // Source of each early write follows directly from the priority policy.
        for (int i = 0; i < 10 && i < obs.size(); i++) begin
            bit is_mem = (obs[i][AW+DW-1:DW] >= AW'(17));
            bit want   = RR ? (i % 2 == 0) : 1'b1;
            total++; if (is_mem !== want)
                begin bad++; $display("FAIL both_src_%0d: got mem=%0b exp mem=%0b", i, is_mem, want); end
        end
    endtask

    initial begin
        RSTn = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        test_reset();
        test_single_alu();
        test_simultaneous();
        test_x0();
        test_back_to_back();
        test_random();
        test_both_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
